// File: rtl/mg_c_bank.sv
// Bank of N_CH clocked Muller C-elements, each joining N_IN asynchronous requests.
// Per channel: input synchroniser, C-element hold/update, edge pulses, disagreement stall timer.
module mg_c_bank #(
   parameter int unsigned      N_IN        = 2,
   parameter int unsigned      N_CH        = 4,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [N_CH-1:0]  RST_VAL     = '0,
   parameter int unsigned      TMO_CYCLES  = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH*N_IN-1:0] a,
   input  logic [N_CH-1:0]      en,
   output logic [N_CH-1:0]      z,
   output logic [N_CH-1:0]      rise,
   output logic [N_CH-1:0]      fall,
   output logic [N_CH-1:0]      pend,
   output logic [N_CH-1:0]      stall
);

   localparam int unsigned   CW  = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMO = CW'(TMO_CYCLES);

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [N_IN-1:0] s;
      logic            all_one;
      logic            all_zero;
      logic            z_q;
      logic            z_nxt;
      logic            rise_q;
      logic            fall_q;
      logic [CW-1:0]   cnt;

      if (SYNC_STAGES == 0) begin : g_direct
         assign s = a[c*N_IN +: N_IN];
      end else begin : g_sync
         logic [N_IN-1:0] sq [SYNC_STAGES];

         // NOTE: every synchroniser stage is reset, and to the channel's z reset value, so
         // the chain already agrees with z at release and no edge pulse can follow reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) sq[i] <= {N_IN{RST_VAL[c]}};
            end else begin
               sq[0] <= a[c*N_IN +: N_IN];
               for (int i = 1; i < SYNC_STAGES; i++) sq[i] <= sq[i-1];
            end
         end

         assign s = sq[SYNC_STAGES-1];
      end

      assign all_one  = &s;
      assign all_zero = ~|s;
      assign pend[c]  = ~(all_one | all_zero);

      always_comb begin
         // NOTE: z_nxt defaults to the held value first, so the disagree path cannot infer a latch.
         z_nxt = z_q;
         if (en[c] && all_one)       z_nxt = 1'b1;
         else if (en[c] && all_zero) z_nxt = 1'b0;
      end

      // NOTE: non-blocking updates so rise/fall compare z_nxt against the pre-edge z_q.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            z_q    <= RST_VAL[c];
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt    <= '0;
         end else begin
            z_q    <= z_nxt;
            rise_q <= z_nxt & ~z_q;
            fall_q <= ~z_nxt & z_q;
            // Agreement clears the timer even while disabled; a disabled cycle only pauses it.
            if (!pend[c])                cnt <= '0;
            else if (en[c] && cnt != TMO) cnt <= cnt + CW'(1);
         end
      end

      assign z[c]     = z_q;
      assign rise[c]  = rise_q;
      assign fall[c]  = fall_q;
      assign stall[c] = (TMO_CYCLES != 0) && (cnt == TMO);
   end

endmodule
